// File: rtl/ternary_mv_stream_pkg.sv
// ---------------------------------------------------------------------------
// tern_pkg
//  Shared definitions for the streaming ternary matrix-vector multiplier.
//  - W_POS / W_NEG  : 2-bit weight codes for +1 / -1 (any other code is 0)
//  - drain_state_t  : result-drain FSM states
//  - tern_mul       : ternary product of a sign-extended element
//  - sat_trunc      : accumulator to output conversion (clamp or wrap)
//  The functions work on fixed FN_W / 2*FN_W wide values so they can be
//  shared by any parameterisation; callers size-cast the result down.
//  Accumulator and data widths therefore must not exceed FN_W bits.
// ---------------------------------------------------------------------------
package tern_pkg;

   localparam logic [1:0] W_POS = 2'b01;
   localparam logic [1:0] W_NEG = 2'b11;
   localparam int         FN_W  = 32;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } drain_state_t;

   // x must already be sign-extended, so negating the most negative
   // element value is exact.
   function automatic logic signed [FN_W-1:0] tern_mul(
      input logic [1:0]             code,
      input logic signed [FN_W-1:0] x
   );
      case (code)
         W_POS:   return x;
         W_NEG:   return -x;
         default: return '0;
      endcase
   endfunction

   // The caller keeps the low data_w bits of the result; without
   // saturation that is plain two's-complement wrap.
   function automatic logic signed [FN_W-1:0] sat_trunc(
      input logic signed [2*FN_W-1:0] acc,
      input int                       data_w,
      input bit                       saturate
   );
      logic signed [2*FN_W-1:0] hi;
      logic signed [2*FN_W-1:0] lo;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (saturate) begin
         if (acc > hi) return hi[FN_W-1:0];
         if (acc < lo) return lo[FN_W-1:0];
      end
      return acc[FN_W-1:0];
   endfunction

endpackage

// File: rtl/ternary_mv_stream_if.sv
// ---------------------------------------------------------------------------
// ternary_mv_stream_if
//  Input beat stream (in_valid/in_ready/in_data) and result stream
//  (out_valid/out_ready/out_data/out_idx/out_last) of ternary_mv_stream.
//  slave  : the multiplier side
//  master : the producer/consumer side driving beats and taking results
// ---------------------------------------------------------------------------
interface ternary_mv_stream_if #(
   parameter int LANES   = 2,
   parameter int DATA_W  = 8,
   parameter int OUT_LEN = 8
);
   localparam int IDX_W = $clog2(OUT_LEN);

   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [IDX_W-1:0]          out_idx;
   logic                      out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/ternary_mv_stream_col_acc.sv
// ---------------------------------------------------------------------------
// ternary_col_acc
//  One output column: ternary products of LANES input elements summed and
//  added to a full-precision accumulator.
//  clk, rst_n : clock / asynchronous active-low reset
//  en         : accepted beat, load acc_next into the accumulator
//  first      : beat 0 of a vector, start from zero instead of the old sum
//  w_codes    : LANES 2-bit weight codes for this column, lane l at [2*l +: 2]
//  x_flat     : LANES signed elements, lane l at [l*DATA_W +: DATA_W]
//  acc_next   : running sum including the current beat
// ---------------------------------------------------------------------------
module ternary_col_acc
   import tern_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 13
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    first,
   input  logic [2*LANES-1:0]      w_codes,
   input  logic [LANES*DATA_W-1:0] x_flat,
   output logic signed [ACC_W-1:0] acc_next
);

   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] term [LANES];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] x_s;
      assign x_s      = x_flat[gi*DATA_W +: DATA_W];
      assign term[gi] = ACC_W'(tern_mul(w_codes[2*gi +: 2], FN_W'(x_s)));
   end

   always_comb begin
      acc_next = first ? '0 : acc_reg;
      for (int l = 0; l < LANES; l++) begin
         acc_next = acc_next + term[l];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else if (en) begin
         acc_reg <= acc_next;
      end
   end

endmodule

// File: rtl/ternary_mv_stream.sv
// ---------------------------------------------------------------------------
// ternary_mv_stream
//  Streaming ternary matrix-vector multiplier y[c] = sum_r W[r][c]*x[r].
//  LANES elements per input beat are accumulated into OUT_LEN columns;
//  after the last beat the converted sums go to a result buffer that is
//  drained one element per cycle while the next vector accumulates.
//  clk, rst_n : clock / asynchronous active-low reset
//  clear      : synchronous abort of the vector in flight and result buffer
//  w_flat     : weights, W[r][c] at [2*(r*OUT_LEN+c) +: 2]
//  bus        : input beat and result streams (slave side)
//  busy       : vector partially accumulated or results pending
// ---------------------------------------------------------------------------
module ternary_mv_stream
   import tern_pkg::*;
#(
   parameter int IN_LEN   = 16,
   parameter int OUT_LEN  = 8,
   parameter int DATA_W   = 8,
   parameter int LANES    = 2,
   parameter int ACC_W    = DATA_W + $clog2(IN_LEN) + 1,
   parameter bit SATURATE = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic [2*IN_LEN*OUT_LEN-1:0]   w_flat,
   ternary_mv_stream_if.slave            bus,
   output logic                          busy
);

   localparam int NBEATS = IN_LEN / LANES;
   localparam int BC_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int IDX_W  = $clog2(OUT_LEN);
   localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(NBEATS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OUT_LEN - 1);

   logic [BC_W-1:0]          beat_cnt_reg, beat_cnt_next;
   logic [IDX_W-1:0]         out_idx_reg, out_idx_next;
   drain_state_t             state_reg, state_next;
   logic [DATA_W-1:0]        obuf_reg [OUT_LEN];
   logic [OUT_LEN*DATA_W-1:0] conv_flat;

   logic last_beat, first_beat, obuf_full, accept, load, out_hs;

   assign last_beat  = (beat_cnt_reg == LAST_BEAT);
   assign first_beat = (beat_cnt_reg == '0);
   assign obuf_full  = (state_reg == S_DRAIN);
   // Only the final beat can be stalled, and only by a still-full buffer;
   // in_ready never depends on out_ready combinationally.
   assign bus.in_ready = !last_beat || !obuf_full;
   assign accept = bus.in_valid && bus.in_ready && !clear;
   assign load   = accept && last_beat;
   assign out_hs = bus.out_valid && bus.out_ready && !clear;

   // ---------------- beat counter ----------------
   always_comb begin
      beat_cnt_next = beat_cnt_reg;
      if (clear) begin
         beat_cnt_next = '0;
      end else if (accept) begin
         beat_cnt_next = last_beat ? '0 : beat_cnt_reg + BC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_reg <= '0;
      end else begin
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   // ---------------- column accumulators ----------------
   for (genvar gi = 0; gi < OUT_LEN; gi++) begin : g_col
      logic [2*LANES-1:0]      w_codes;
      logic signed [ACC_W-1:0] acc_next;

      // Weight rows for the current beat: row = beat*LANES + lane.
      always_comb begin
         w_codes = '0;
         for (int l = 0; l < LANES; l++) begin
            w_codes[2*l +: 2] =
               w_flat[2*((int'(beat_cnt_reg)*LANES + l)*OUT_LEN + gi) +: 2];
         end
      end

      ternary_col_acc #(
         .LANES  (LANES),
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_col (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (accept),
         .first    (first_beat),
         .w_codes  (w_codes),
         .x_flat   (bus.in_data),
         .acc_next (acc_next)
      );

      assign conv_flat[gi*DATA_W +: DATA_W] =
         DATA_W'(sat_trunc((2*FN_W)'(acc_next), DATA_W, SATURATE));
   end

   // ---------------- result buffer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < OUT_LEN; c++) begin
            obuf_reg[c] <= '0;
         end
      end else if (load) begin
         for (int c = 0; c < OUT_LEN; c++) begin
            obuf_reg[c] <= conv_flat[c*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------- drain FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         out_idx_reg <= '0;
      end else begin
         state_reg   <= state_next;
         out_idx_reg <= out_idx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      out_idx_next = out_idx_reg;
      case (state_reg)
         S_IDLE: begin
            if (load) begin
               state_next   = S_DRAIN;
               out_idx_next = '0;
            end
         end
         S_DRAIN: begin
            if (out_hs) begin
               if (out_idx_reg == LAST_IDX) begin
                  state_next   = S_IDLE;
                  out_idx_next = '0;
               end else begin
                  out_idx_next = out_idx_reg + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next   = S_IDLE;
            out_idx_next = '0;
         end
      endcase
      if (clear) begin
         state_next   = S_IDLE;
         out_idx_next = '0;
      end
   end

   // out_data is forced to zero while nothing is being presented.
   always_comb begin
      bus.out_valid = (state_reg == S_DRAIN);
      bus.out_idx   = out_idx_reg;
      bus.out_last  = bus.out_valid && (out_idx_reg == LAST_IDX);
      bus.out_data  = bus.out_valid ? obuf_reg[out_idx_reg] : '0;
      busy          = (beat_cnt_reg != '0) || bus.out_valid;
   end

endmodule

// File: tb/tb_ternary_mv_stream.sv
// ---------------------------------------------------------------------------
// tb_ternary_mv_stream
//  Two instances (saturating and wrapping) share one stimulus stream.
//  A reference model computes each y[c] directly from the weight matrix and
//  vector and queues the expected results; handshake state is derived from
//  that queue (results pending <=> buffer full).
// ---------------------------------------------------------------------------
module tb_ternary_mv_stream;

   localparam int IN_LEN  = 16;
   localparam int OUT_LEN = 8;
   localparam int DATA_W  = 8;
   localparam int LANES   = 2;
   localparam int NB      = IN_LEN / LANES;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [LANES*DATA_W-1:0] in_data = '0;
   logic [2*IN_LEN*OUT_LEN-1:0] w_flat = '0;
   logic busy_s, busy_w;

   always #5 clk = ~clk;

   ternary_mv_stream_if #(.LANES(LANES), .DATA_W(DATA_W), .OUT_LEN(OUT_LEN)) bus_s ();
   ternary_mv_stream_if #(.LANES(LANES), .DATA_W(DATA_W), .OUT_LEN(OUT_LEN)) bus_w ();

   assign bus_s.in_valid  = in_valid;
   assign bus_s.in_data   = in_data;
   assign bus_s.out_ready = out_ready;
   assign bus_w.in_valid  = in_valid;
   assign bus_w.in_data   = in_data;
   assign bus_w.out_ready = out_ready;

   ternary_mv_stream #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DATA_W),
                       .LANES(LANES), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .clear(clear), .w_flat(w_flat),
      .bus(bus_s.slave), .busy(busy_s));

   ternary_mv_stream #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DATA_W),
                       .LANES(LANES), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst_n(rst_n), .clear(clear), .w_flat(w_flat),
      .bus(bus_w.slave), .busy(busy_w));

   typedef struct packed {
      logic [7:0] ds;
      logic [7:0] dw;
      logic [2:0] idx;
      logic       last;
   } exp_t;

   typedef struct {
      int         mw;
      int         mx;
      logic [7:0] s0;
      logic [7:0] s7;
      logic [7:0] w0;
   } tv_t;

   exp_t exp_q[$];
   logic [1:0] cur_w [IN_LEN][OUT_LEN];
   int cur_x [IN_LEN];
   int beat = 0, vec_left = 0, stall_cnt = 0, p_in = 0, p_out = 0;
   int cur_mw = 0, cur_mx = 0;
   bit have_vec = 1'b0;
   int checks = 0, errors = 0;
   logic [7:0] cap_s [OUT_LEN];
   logic [7:0] cap_w [OUT_LEN];
   logic       cap_last [OUT_LEN];
   tv_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int tern(input logic [1:0] c);
      if (c == 2'b01) return 1;
      if (c == 2'b11) return -1;
      return 0;
   endfunction

   // mw: 0 random codes, 1 identity, 2 all +1, 3 all -1, 4 all 2'b10, 5 -identity
   // mx: 0 random, 1 r+1, 2 all 127, 3 all -128
   task automatic gen_vec();
      for (int r = 0; r < IN_LEN; r++) begin
         for (int c = 0; c < OUT_LEN; c++) begin
            case (cur_mw)
               0: cur_w[r][c] = 2'($urandom_range(3));
               1: cur_w[r][c] = (r == c) ? 2'b01 : 2'b00;
               2: cur_w[r][c] = 2'b01;
               3: cur_w[r][c] = 2'b11;
               4: cur_w[r][c] = 2'b10;
               default: cur_w[r][c] = (r == c) ? 2'b11 : 2'b10;
            endcase
         end
         case (cur_mx)
            0: cur_x[r] = int'($urandom_range(255)) - 128;
            1: cur_x[r] = r + 1;
            2: cur_x[r] = 127;
            default: cur_x[r] = -128;
         endcase
      end
   endtask

   task automatic push_expected();
      exp_t e;
      int y, s;
      for (int c = 0; c < OUT_LEN; c++) begin
         y = 0;
         for (int r = 0; r < IN_LEN; r++) y += tern(cur_w[r][c]) * cur_x[r];
         s = (y > 127) ? 127 : ((y < -128) ? -128 : y);
         e.ds   = 8'(s);
         e.dw   = y[7:0];
         e.idx  = 3'(c);
         e.last = (c == OUT_LEN - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive();
      in_valid = have_vec && (int'($urandom_range(99)) < p_in);
      for (int l = 0; l < LANES; l++) in_data[l*DATA_W +: DATA_W] = 8'(cur_x[beat*LANES + l]);
      for (int r = 0; r < IN_LEN; r++)
         for (int c = 0; c < OUT_LEN; c++) w_flat[2*(r*OUT_LEN + c) +: 2] = cur_w[r][c];
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else begin
         out_ready = (int'($urandom_range(99)) < p_out);
      end
   endtask

   // One clock: check at the falling edge, update the model for the
   // handshakes that the next rising edge will take, then drive.
   task automatic cycle();
      exp_t e;
      bit pend;
      @(negedge clk);
      pend = (exp_q.size() != 0);
      chk("out_valid", 32'(bus_s.out_valid), 32'(pend));
      chk("out_valid_w", 32'(bus_w.out_valid), 32'(pend));
      chk("in_ready", 32'(bus_s.in_ready), 32'((beat != NB - 1) || !pend));
      chk("in_ready_w", 32'(bus_w.in_ready), 32'((beat != NB - 1) || !pend));
      chk("busy", 32'(busy_s), 32'((beat != 0) || pend));
      if (bus_s.out_valid && pend) begin
         e = exp_q[0];
         chk("out_data_sat", 32'(bus_s.out_data), 32'(e.ds));
         chk("out_data_wrap", 32'(bus_w.out_data), 32'(e.dw));
         chk("out_idx", 32'(bus_s.out_idx), 32'(e.idx));
         chk("out_last", 32'(bus_s.out_last), 32'(e.last));
      end
      if (clear) begin
         exp_q.delete();
         beat = 0;
         if (have_vec) gen_vec();
      end else begin
         if (bus_s.out_valid && out_ready && pend) begin
            e = exp_q.pop_front();
            cap_s[e.idx] = e.ds;
            cap_w[e.idx] = e.dw;
            cap_s[e.idx] = bus_s.out_data;
            cap_w[e.idx] = bus_w.out_data;
            cap_last[e.idx] = bus_s.out_last;
         end
         if (in_valid && bus_s.in_ready) begin
            beat++;
            if (beat == NB) begin
               push_expected();
               beat = 0;
               vec_left--;
               if (vec_left > 0) gen_vec();
               else have_vec = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_vectors(input int n, input int mw, input int mx, input int pi,
                              input int po, input int stall, input int maxc);
      int cyc = 0;
      cur_mw = mw; cur_mx = mx; p_in = pi; p_out = po; stall_cnt = stall;
      vec_left = n; have_vec = 1'b1;
      gen_vec();
      drive();
      while ((have_vec || exp_q.size() != 0) && cyc < maxc) begin
         cycle();
         cyc++;
      end
      chk("run_done", 32'(have_vec || exp_q.size() != 0), 32'(0));
   endtask

   initial begin
      int cyc;
      tbl[0] = '{mw: 1, mx: 1, s0: 8'd1,   s7: 8'd8,   w0: 8'd1};
      tbl[1] = '{mw: 2, mx: 2, s0: 8'd127, s7: 8'd127, w0: 8'hF0};
      tbl[2] = '{mw: 3, mx: 3, s0: 8'd127, s7: 8'd127, w0: 8'h00};
      tbl[3] = '{mw: 2, mx: 3, s0: 8'h80,  s7: 8'h80,  w0: 8'h00};
      tbl[4] = '{mw: 4, mx: 2, s0: 8'h00,  s7: 8'h00,  w0: 8'h00};
      tbl[5] = '{mw: 5, mx: 1, s0: 8'hFF,  s7: 8'hF8,  w0: 8'hFF};

      // reset state
      #12;
      chk("rst_in_ready", 32'(bus_s.in_ready), 32'(1));
      chk("rst_out_valid", 32'(bus_s.out_valid), 32'(0));
      chk("rst_out_data", 32'(bus_s.out_data), 32'(0));
      chk("rst_out_idx", 32'(bus_s.out_idx), 32'(0));
      chk("rst_out_last", 32'(bus_s.out_last), 32'(0));
      chk("rst_busy", 32'(busy_s), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();
      repeat (2) cycle();

      // directed table
      for (int t = 0; t < 6; t++) begin
         for (int c = 0; c < OUT_LEN; c++) cap_last[c] = 1'b0;
         run_vectors(1, tbl[t].mw, tbl[t].mx, 100, 100, 0, 200);
         $display("table %0d: y0=%0h y7=%0h wrap0=%0h", t, cap_s[0], cap_s[7], cap_w[0]);
         chk("tbl_sat_y0", 32'(cap_s[0]), 32'(tbl[t].s0));
         chk("tbl_sat_y7", 32'(cap_s[7]), 32'(tbl[t].s7));
         chk("tbl_wrap_y0", 32'(cap_w[0]), 32'(tbl[t].w0));
         chk("tbl_last7", 32'(cap_last[7]), 32'(1));
         chk("tbl_last0", 32'(cap_last[0]), 32'(0));
      end

      // backpressure: results held while the next vector streams in
      run_vectors(2, 0, 0, 100, 100, 28, 400);
      $display("backpressure: 2 vectors drained");

      // clear mid-vector
      cur_mw = 0; cur_mx = 0; p_in = 100; p_out = 100; stall_cnt = 0;
      vec_left = 1; have_vec = 1'b1;
      gen_vec();
      drive();
      repeat (3) cycle();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clr_vec_busy", 32'(busy_s), 32'(0));
      chk("clr_vec_out_valid", 32'(bus_s.out_valid), 32'(0));
      cyc = 0;
      while ((have_vec || exp_q.size() != 0) && cyc < 200) begin
         cycle();
         cyc++;
      end
      chk("clr_vec_done", 32'(have_vec || exp_q.size() != 0), 32'(0));
      $display("clear mid-vector: following vector drained");

      // clear mid-drain
      vec_left = 1; have_vec = 1'b1;
      gen_vec();
      drive();
      cyc = 0;
      while (exp_q.size() != 6 && cyc < 100) begin
         cycle();
         cyc++;
      end
      chk("clr_drain_reached", 32'(exp_q.size()), 32'(6));
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clr_drain_out_valid", 32'(bus_s.out_valid), 32'(0));
      chk("clr_drain_out_idx", 32'(bus_s.out_idx), 32'(0));
      chk("clr_drain_busy", 32'(busy_s), 32'(0));
      run_vectors(1, 0, 0, 100, 100, 0, 200);
      $display("clear mid-drain: following vector drained");

      // asynchronous reset while results are stalled
      cur_mw = 0; cur_mx = 0; p_in = 100;
      vec_left = 1; have_vec = 1'b1; stall_cnt = 1000;
      gen_vec();
      drive();
      cyc = 0;
      while (exp_q.size() == 0 && cyc < 100) begin
         cycle();
         cyc++;
      end
      repeat (3) cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus_s.out_valid), 32'(0));
      chk("arst_out_data", 32'(bus_s.out_data), 32'(0));
      chk("arst_out_idx", 32'(bus_s.out_idx), 32'(0));
      chk("arst_out_last", 32'(bus_s.out_last), 32'(0));
      chk("arst_busy", 32'(busy_s), 32'(0));
      chk("arst_in_ready", 32'(bus_s.in_ready), 32'(1));
      $display("async reset mid-drain: outputs sampled");
      exp_q.delete();
      beat = 0; have_vec = 1'b0; stall_cnt = 0; vec_left = 0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();
      repeat (2) cycle();

      // randomized vectors with gaps on both sides
      run_vectors(200, 0, 0, 70, 60, 0, 20000);
      $display("random: 200 vectors drained");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
